// File: rtl/vote_display.sv
// rtl/vote_display.sv - 12-bit binary to 4-digit BCD converter driving a multiplexed 7-segment display
module vote_display #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        Power,
  input  logic [11:0] value,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [15:0] bcd,
  output logic        busy
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [11:0]     cap_q, cap_d;
  logic [27:0]     sh_q, sh_d;
  logic [3:0]      iter_q, iter_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [CW-1:0]   refresh_q, refresh_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;

  logic [27:0]     adj;
  logic [3:0]      digit;
  logic            lead_zero;
  logic [6:0]      seg_al;
  logic [3:0]      an_al;

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    sh_d    = sh_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    adj     = sh_q;
    case (state_q)
      S_IDLE: if (value != cap_q) state_d = S_LOAD;
      S_LOAD: begin
        cap_d   = value;
        sh_d    = {16'b0, value};
        iter_d  = 4'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        for (int n = 0; n < 4; n++) begin
          if (adj[12+4*n +: 4] >= 4'd5) adj[12+4*n +: 4] = adj[12+4*n +: 4] + 4'd3;
        end
        sh_d   = {adj[26:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd11) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = sh_q[27:12];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    refresh_d = refresh_q + 1'b1;
    idx_d     = idx_q;
    if (refresh_q == REFRESH_LAST) begin
      refresh_d = '0;
      idx_d     = idx_q + 2'd1;
    end

    digit = bcd_q[{idx_q, 2'b00} +: 4];
    case (idx_q)
      2'd1:    lead_zero = (bcd_q[15:4] == 12'd0);
      2'd2:    lead_zero = (bcd_q[15:8] == 8'd0);
      2'd3:    lead_zero = (bcd_q[15:12] == 4'd0);
      default: lead_zero = 1'b0;
    endcase

    case (digit)
      4'd0:    seg_al = 7'b1000000;
      4'd1:    seg_al = 7'b1111001;
      4'd2:    seg_al = 7'b0100100;
      4'd3:    seg_al = 7'b0110000;
      4'd4:    seg_al = 7'b0011001;
      4'd5:    seg_al = 7'b0010010;
      4'd6:    seg_al = 7'b0000010;
      4'd7:    seg_al = 7'b1111000;
      4'd8:    seg_al = 7'b0000000;
      4'd9:    seg_al = 7'b0010000;
      default: seg_al = 7'b1111111;
    endcase
    an_al = ~(4'b0001 << idx_q);

    // a blanked slot keeps its time share but lights nothing
    if (BLANK_LZ && lead_zero) begin
      seg_al = 7'b1111111;
      an_al  = 4'b1111;
    end

    seg_d = SEG_ACTIVE_LOW ? seg_al : ~seg_al;
    an_d  = SEG_ACTIVE_LOW ? an_al : ~an_al;
  end

  always_ff @(posedge clk or negedge Power) begin
    if (!Power) begin
      state_q   <= S_IDLE;
      cap_q     <= 12'd0;
      sh_q      <= 28'd0;
      iter_q    <= 4'd0;
      bcd_q     <= 16'd0;
      refresh_q <= '0;
      idx_q     <= 2'd0;
      seg_q     <= SEG_OFF;
      an_q      <= AN_OFF;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      sh_q      <= sh_d;
      iter_q    <= iter_d;
      bcd_q     <= bcd_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign bcd  = bcd_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: doc/vote_display.md
Name: vote_display

Overview:
- Downstream stage of the ballot counter.
- Takes the counter's 12-bit binary result bus (running total or per-candidate tally) and converts it sequentially to 4-digit BCD using shift-add-3.
- Drives a time-multiplexed 4-digit 7-segment display, with optional leading-zero blanking.
- Sits between the vote-counting block and the board's display pins.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays enabled; legal range ≥2.
- BLANK_LZ, 1: 1 = blank leading zeros (units digit never blanked); 0 = always show 4 digits.
- SEG_ACTIVE_LOW, 1: 1 = seg and an are active-low; 0 = active-high.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- Power, input, 1: asynchronous, active-low reset (Power=0 resets).
- value, input, 12: binary count from the vote counter, 0..4095.
- seg, output, 7: segment drive {g,f,e,d,c,b,a}; registered.
- an, output, 4: digit enables; an[0] = units … an[3] = thousands; registered.
- bcd, output, 16: last converted result {thousands,hundreds,tens,units}.
- busy, output, 1: high while a conversion is in progress.

Behaviour:
- Reset (Power=0, asynchronous):
  - Converter FSM → IDLE; captured value cap=0; bcd=0; busy=0.
  - Refresh counter=0; digit index=0.
  - an = all inactive (4'b1111 when active-low); seg = all off (7'h7F when active-low).
  - Reset asserted mid-conversion aborts the conversion immediately; no partial result reaches bcd.
- Converter FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: busy=0. If value≠cap, go to LOAD; otherwise stay in IDLE.
  - LOAD: cap<=value; shift register <= {16'b0, value}; iteration count=0; busy=1.
  - SHIFT: one iteration per cycle. First add 3 to every BCD nibble ≥5, then shift the 28-bit register left by 1. After 12 iterations go to DONE.
  - DONE: bcd <= upper 16 bits of the shift register; return to IDLE.
- Latency:
  - For a value change seen by IDLE at edge k: LOAD at k+1, SHIFT at k+2..k+13, bcd updates at edge k+14.
  - busy is high from edge k+1 through edge k+14 (14 cycles).
- Change during conversion:
  - value is not re-sampled until the FSM is back in IDLE.
  - If value still differs from cap, a new conversion starts. Intermediate values may be skipped; the final value is always converted.
- Value 0 after reset needs no conversion, because cap=0 and bcd=0 are already consistent.
- Arithmetic:
  - Thousands nibble is at most 4 (4095 → 16'h4095).
  - Nibble add-3 is 4-bit and cannot overflow given the ≥5 test.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index advances 0→1→2→3→0.
- Digit output:
  - seg/an are registered from the current digit index and bcd, one cycle behind the index.
  - Exactly one an bit is active unless that digit is blanked.
  - A blanked digit drives an all inactive and seg off for that slot.
- Leading-zero blanking (BLANK_LZ=1): digit i (i≥1) is blanked when nibbles i..3 of bcd are all zero.
- Segment decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other code → off.
  - SEG_ACTIVE_LOW=0 inverts both seg and an.
- Display during conversion: the display keeps showing the old bcd until DONE, so no partial digits are ever displayed.

Test Plan:
- Reset: Power=0 with clk running → an=1111, seg=1111111, bcd=0, busy=0. Release with value=0 → next edge an=1110, seg=1000000; no conversion starts (busy stays 0).
- Conversion (REFRESH_DIV=4): value=1234 → busy high 14 cycles, then bcd=16'h1234. an cycles 1110/1101/1011/0111, 4 cycles each, with seg 0011001/0110000/0100100/1111001.
- Maximum: value=4095 → bcd=16'h4095. Thousands digit shows 0011001.
- Blanking: BLANK_LZ=1, value=7 → units slot shows seg=1111000 with an=1110; the other three slots have an=1111. With BLANK_LZ=0 → all four digits shown, leading three with seg=1000000.
- Change mid-conversion: value=100, then value=200 three cycles later → bcd=16'h0100 first; busy drops for exactly one cycle (IDLE); then bcd=16'h0200, 14 cycles later.
- Reset mid-conversion: Power=0 during SHIFT → bcd stays at 0 from reset, busy=0 immediately (asynchronously). After release with value=55 → bcd=16'h0055 after 15 edges.
